top_mod: RTL and testbench



---
 rtl/top_mod_pkg.sv | 9 +
 rtl/top_mod_delay.sv | 40 ++++
 rtl/top_mod.sv | 43 ++++
 tb/tb_top_mod.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/top_mod_pkg.sv
// Shared constants for the top_mod registered Boolean function block.
//   TOP_MOD_MAX_LATENCY : deepest pipeline top_mod may be built with
//   Q_RESET             : value every pipeline stage and Q take on reset
package top_mod_pkg;

  localparam int unsigned TOP_MOD_MAX_LATENCY = 8;
  localparam logic        Q_RESET             = 1'b0;

endpackage

// File: rtl/top_mod_delay.sv
// Depth-stage 1-bit shift register with synchronous active-high reset.
// Ports:
//   clk_i : clock, all updates on the rising edge
//   rst_i : synchronous active-high reset, clears every stage to Q_RESET
//   d_i   : bit captured into stage 0 each rising edge
//   q_o   : last stage, i.e. d_i delayed by Depth rising edges
module top_mod_delay
  import top_mod_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] stage_q;
  logic [Depth-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset discards every in-flight value at once; nothing drains out afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {Depth{Q_RESET}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/top_mod.sv
// Registered 4-input Boolean function: Q = (A & B) | (C & D), delayed by
// LATENCY rising edges. Used as a clean registered decision flag.
// Ports:
//   clk : system clock, rising-edge active
//   rst : synchronous active-high reset, clears the pipeline and Q
//   A,B : first AND term operands
//   C,D : second AND term operands
//   Q   : registered result, inputs before edge k appear after edge k+LATENCY-1
module top_mod
  import top_mod_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Q
);

  if (LATENCY < 1 || LATENCY > TOP_MOD_MAX_LATENCY) begin : gen_bad_latency
    $error("top_mod: LATENCY %0d outside 1..%0d", LATENCY, TOP_MOD_MAX_LATENCY);
  end

  logic f;

  always_comb begin
    f = (A & B) | (C & D);
  end

  // Only the registered stages reach Q, so mid-cycle input activity cannot glitch it.
  top_mod_delay #(
    .Depth (LATENCY)
  ) u_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (f),
    .q_o   (Q)
  );

endmodule

// File: tb/tb_top_mod.sv
// Self-checking bench for top_mod. Two instances (LATENCY 1 and 3) share the
// stimulus; a per-instance expectation queue is filled as inputs are driven
// and drained as each instance's output becomes due.
module tb_top_mod;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic q_l1, q_l3;

  int n_vec;
  int n_err;

  bit exp_q1[$];
  bit exp_q3[$];
  bit last_exp1;
  bit last_exp3;

  top_mod #(
    .LATENCY (1)
  ) u_dut_l1 (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .C   (c),
    .D   (d),
    .Q   (q_l1)
  );

  top_mod #(
    .LATENCY (3)
  ) u_dut_l3 (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .C   (c),
    .D   (d),
    .Q   (q_l3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit model_f(input logic [3:0] abcd);
    // abcd[3]=A, abcd[2]=B, abcd[1]=C, abcd[0]=D
    return bit'((abcd[3] & abcd[2]) | (abcd[1] & abcd[0]));
  endfunction

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic r, input logic [3:0] abcd);
    if (r) begin
      // Reset empties both pipelines; each then shows 0 for its full depth.
      exp_q1.delete();
      exp_q3.delete();
      exp_q1.push_back(1'b0);
      repeat (3) exp_q3.push_back(1'b0);
    end else begin
      exp_q1.push_back(model_f(abcd));
      exp_q3.push_back(model_f(abcd));
    end
  endtask

  task automatic compare_outputs(input string tag);
    if (exp_q1.size() >= 1) begin
      last_exp1 = exp_q1.pop_front();
      check_eq({tag, "/l1"}, q_l1, last_exp1);
    end
    if (exp_q3.size() >= 3) begin
      last_exp3 = exp_q3.pop_front();
      check_eq({tag, "/l3"}, q_l3, last_exp3);
    end
  endtask

  // One cycle: drive on the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic r, input logic [3:0] abcd);
    @(negedge clk);
    rst = r;
    {a, b, c, d} = abcd;
    push_exp(r, abcd);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  // Toggle C/D between edges with A=B=0; Q must hold until the edge.
  task automatic glitch_step();
    logic [1:0] cd;
    @(negedge clk);
    rst = 1'b0;
    a = 1'b0;
    b = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cd = 2'(i);
      {c, d} = cd;
      #1;
      check_eq("glitch_hold/l1", q_l1, last_exp1);
      check_eq("glitch_hold/l3", q_l3, last_exp3);
    end
    push_exp(1'b0, 4'b0000);
    @(posedge clk);
    #1;
    compare_outputs("glitch_edge");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_exp1 = 1'b0;
    last_exp3 = 1'b0;
    rst = 1'b1;
    {a, b, c, d} = 4'b0000;

    // Reset, then reset held while inputs would give 1.
    step("reset", 1'b1, 4'b0000);
    step("reset_hold", 1'b1, 4'b1111);
    step("reset_hold", 1'b1, 4'b1111);

    // Basic function after release.
    step("basic_0111", 1'b0, 4'b0111);
    step("basic_0101", 1'b0, 4'b0101);
    step("basic_1111a", 1'b0, 4'b1111);
    step("basic_1111b", 1'b0, 4'b1111);

    // Exhaustive sweep, one value per cycle.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%0h", i), 1'b0, 4'(i));
    end

    // Single-cycle pulse for latency placement.
    step("pulse_1100", 1'b0, 4'b1100);
    repeat (4) step("pulse_tail", 1'b0, 4'b0000);

    // Fill the pipeline with ones, then reset mid-flight.
    repeat (3) step("load_ones", 1'b0, 4'b1111);
    step("mid_reset", 1'b1, 4'b0000);
    repeat (3) step("post_reset", 1'b0, 4'b0000);

    // Truth-table spot values.
    step("tt_1010", 1'b0, 4'b1010);
    step("tt_0011", 1'b0, 4'b0011);
    step("tt_1001", 1'b0, 4'b1001);

    glitch_step();
    repeat (3) step("flush", 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
